// File: rtl/noc_out_port.sv
// ---------------------------------------------------------------------------
// noc_out_port
//
// Output-port stage of the 5-port NoC router. There is one instance per
// direction (N, S, E, W, L), placed directly downstream of the route logic.
// This stage does four things:
//   - owns the one-hot round-robin token that the route logic checks before
//     it grants a flit,
//   - registers the granted flit onto the outgoing link,
//   - tracks free space in the downstream buffer with a credit counter,
//   - flags protocol violations in a sticky error bit.
//
// Parameters
//   DEPTH        flit capacity of the downstream input buffer (1..15). This
//                is both the initial and the maximum credit count.
//
// Ports
//   clk          single clock; all state changes on the rising edge
//   rst_n        asynchronous, active-low reset
//   N/S/E/W/L_data_i  head flits of the five input buffers ([7:4] X, [3:0] Y)
//   port_select  source select: 000 N, 001 S, 010 E, 011 W, 100 L
//   port_enable  the route logic grants a flit to this port this cycle
//   credit_in    one-cycle pulse: the downstream buffer freed one slot
//   turn         one-hot round-robin token (10000 N ... 00001 L)
//   port_full    high when no credits remain
//   data_o       registered outgoing flit
//   valid_o      one-cycle strobe that qualifies data_o
//   credits      current credit count (for debug and verification)
//   err          sticky protocol-error flag
// ---------------------------------------------------------------------------
module noc_out_port #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] N_data_i,
    input  logic [7:0] S_data_i,
    input  logic [7:0] E_data_i,
    input  logic [7:0] W_data_i,
    input  logic [7:0] L_data_i,
    input  logic [2:0] port_select,
    input  logic       port_enable,
    input  logic       credit_in,
    output logic [4:0] turn,
    output logic       port_full,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic [3:0] credits,
    output logic       err
);

    localparam logic [3:0] MAX_CREDITS = 4'(DEPTH);

    logic [3:0] count;
    logic [7:0] sel_data;
    logic       sel_legal;
    logic       send;
    logic       bad_grant;
    logic       overflow;

    assign credits   = count;
    assign port_full = (count == 4'd0);

    // Select the granted source. Codes 101..111 are not legal sources; for
    // those codes the mux output is zero and it is never captured.
    always_comb begin
        sel_data  = 8'h00;
        sel_legal = 1'b1;
        case (port_select)
            3'b000:  sel_data = N_data_i;
            3'b001:  sel_data = S_data_i;
            3'b010:  sel_data = E_data_i;
            3'b011:  sel_data = W_data_i;
            3'b100:  sel_data = L_data_i;
            default: sel_legal = 1'b0;
        endcase
    end

    // A send needs a grant, a free downstream slot and a legal source.
    // A grant that fails either of the last two conditions is a protocol
    // error. A credit returned while already at the maximum is also an
    // error, unless a send in the same cycle absorbs it.
    always_comb begin
        send      = port_enable && !port_full && sel_legal;
        bad_grant = port_enable && (port_full || !sel_legal);
        overflow  = credit_in && !send && (count == MAX_CREDITS);
    end

    // Register the link, the token and the credit count.
    // The token rotates right every cycle, whether or not a grant occurs, so
    // each source gets a slot once every five cycles. When a send and a
    // credit return happen in the same cycle, the count is unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            turn    <= 5'b10000;
            count   <= MAX_CREDITS;
            data_o  <= 8'h00;
            valid_o <= 1'b0;
            err     <= 1'b0;
        end else begin
            turn    <= {turn[0], turn[4:1]};
            valid_o <= send;
            if (send) begin
                data_o <= sel_data;
            end
            case ({send, credit_in})
                2'b10:   count <= count - 4'd1;
                2'b01:   if (count != MAX_CREDITS) count <= count + 4'd1;
                default: count <= count;
            endcase
            if (bad_grant || overflow) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_noc_out_port.sv
// ---------------------------------------------------------------------------
// tb_noc_out_port
//
// Directed testbench for noc_out_port. Every cycle in which the stimulus
// expects a flit to go out, the stimulus pushes that flit into a
// scoreboard queue, tagged with the cycle in which it should appear on the
// link. A separate monitor watches valid_o on the falling edge. When valid_o
// is high, the monitor pops an entry and compares it. It also reports a
// flit that was expected but did not appear, and a flit that appeared but
// was not expected. Register-level state (credits, port_full, err, turn) is
// checked directly against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_noc_out_port;

    localparam logic [7:0] N_VAL = 8'h11;
    localparam logic [7:0] S_VAL = 8'h22;
    localparam logic [7:0] E_VAL = 8'h33;
    localparam logic [7:0] W_VAL = 8'h44;

    logic       clk;
    logic       rst_n;
    logic [7:0] N_data_i, S_data_i, E_data_i, W_data_i, L_data_i;
    logic [2:0] port_select;
    logic       port_enable;
    logic       credit_in;
    logic [4:0] turn;
    logic       port_full;
    logic [7:0] data_o;
    logic       valid_o;
    logic [3:0] credits;
    logic       err;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   cycle  = 0;
    int   checks = 0;
    int   errors = 0;

    noc_out_port #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .N_data_i    (N_data_i),
        .S_data_i    (S_data_i),
        .E_data_i    (E_data_i),
        .W_data_i    (W_data_i),
        .L_data_i    (L_data_i),
        .port_select (port_select),
        .port_enable (port_enable),
        .credit_in   (credit_in),
        .turn        (turn),
        .port_full   (port_full),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .credits     (credits),
        .err         (err)
    );

    // Free-running clock with a 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to timestamp expected link transfers.
    always @(posedge clk) begin
        cycle++;
    end

    // Monitor: compare link activity against the scoreboard on the falling
    // edge, well away from the edge that updates the outputs.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due <= cycle) begin
            checks++;
            if (!valid_o || data_o !== sb[0].data || sb[0].due != cycle) begin
                errors++;
                $display("[TB] FAIL link_flit: got valid=%0b data=%h, required valid=1 data=%h (due cycle %0d, now %0d)",
                         valid_o, data_o, sb[0].data, sb[0].due, cycle);
            end
            void'(sb.pop_front());
        end else if (valid_o === 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_flit: got valid=1 data=%h, required valid=0", data_o);
        end
    end

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp_v);
        end
    endtask

    // Drive one cycle of stimulus just after a rising edge. When a send is
    // expected, queue the flit for the next cycle. Return just after the
    // edge that samples the stimulus, so that callers see its effect.
    task automatic applyStimulus(input logic [2:0] sel, input logic en, input logic cin,
                                 input logic [7:0] ldata, input logic exp_send,
                                 input logic [7:0] exp_data);
        exp_t e;
        port_select = sel;
        port_enable = en;
        credit_in   = cin;
        L_data_i    = ldata;
        if (exp_send) begin
            e.data = exp_data;
            e.due  = cycle + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between clock edges and return just after the next edge.
    task automatic pulseReset();
        port_enable = 1'b0;
        credit_in   = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        N_data_i    = N_VAL;
        S_data_i    = S_VAL;
        E_data_i    = E_VAL;
        W_data_i    = W_VAL;
        L_data_i    = 8'h00;
        port_select = 3'b000;
        port_enable = 1'b0;
        credit_in   = 1'b0;
        rst_n       = 1'b0;

        // Reset state, and the token rotating after reset is released.
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("reset_turn",    {3'b0, turn}, 8'h10);
        checkOutput("reset_credits", {4'b0, credits}, 8'h04);
        checkOutput("reset_full",    {7'b0, port_full}, 8'h00);
        checkOutput("reset_valid",   {7'b0, valid_o}, 8'h00);
        checkOutput("reset_err",     {7'b0, err}, 8'h00);
        checkOutput("reset_data",    data_o, 8'h00);
        applyStimulus(3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("turn_1", {3'b0, turn}, 8'h08);
        applyStimulus(3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("turn_2", {3'b0, turn}, 8'h04);
        applyStimulus(3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("turn_3", {3'b0, turn}, 8'h02);
        applyStimulus(3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("turn_4", {3'b0, turn}, 8'h01);
        applyStimulus(3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("turn_5", {3'b0, turn}, 8'h10);

        // Single send from L. After the send, the link goes idle and data_o
        // holds the flit.
        applyStimulus(3'b100, 1'b1, 1'b0, 8'h24, 1'b1, 8'h24);
        checkOutput("single_valid",   {7'b0, valid_o}, 8'h01);
        checkOutput("single_credits", {4'b0, credits}, 8'h03);
        applyStimulus(3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("single_idle_valid", {7'b0, valid_o}, 8'h00);
        checkOutput("single_hold_data",  data_o, 8'h24);

        // Return one credit to get back to a full count of 4.
        applyStimulus(3'b000, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
        checkOutput("return_credits", {4'b0, credits}, 8'h04);
        checkOutput("return_err",     {7'b0, err}, 8'h00);

        // Exhaust the credits with four back-to-back sends from N, S, E, W.
        applyStimulus(3'b000, 1'b1, 1'b0, 8'h00, 1'b1, N_VAL);
        checkOutput("exhaust_c3", {4'b0, credits}, 8'h03);
        applyStimulus(3'b001, 1'b1, 1'b0, 8'h00, 1'b1, S_VAL);
        checkOutput("exhaust_c2", {4'b0, credits}, 8'h02);
        applyStimulus(3'b010, 1'b1, 1'b0, 8'h00, 1'b1, E_VAL);
        checkOutput("exhaust_c1",   {4'b0, credits}, 8'h01);
        checkOutput("exhaust_full1", {7'b0, port_full}, 8'h00);
        applyStimulus(3'b011, 1'b1, 1'b0, 8'h00, 1'b1, W_VAL);
        checkOutput("exhaust_c0",   {4'b0, credits}, 8'h00);
        checkOutput("exhaust_full", {7'b0, port_full}, 8'h01);
        checkOutput("exhaust_err0", {7'b0, err}, 8'h00);
        applyStimulus(3'b000, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("over_grant_valid",   {7'b0, valid_o}, 8'h00);
        checkOutput("over_grant_err",     {7'b0, err}, 8'h01);
        checkOutput("over_grant_credits", {4'b0, credits}, 8'h00);

        // Return a credit. Then send and return a credit in the same cycle:
        // the count stays at 1.
        applyStimulus(3'b000, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
        checkOutput("refill_credits", {4'b0, credits}, 8'h01);
        checkOutput("refill_full",    {7'b0, port_full}, 8'h00);
        applyStimulus(3'b100, 1'b1, 1'b1, 8'h5a, 1'b1, 8'h5a);
        checkOutput("simul_credits", {4'b0, credits}, 8'h01);
        checkOutput("simul_full",    {7'b0, port_full}, 8'h00);
        checkOutput("simul_valid",   {7'b0, valid_o}, 8'h01);
        applyStimulus(3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);

        // Credit overflow at the maximum count.
        pulseReset();
        checkOutput("rst2_err",     {7'b0, err}, 8'h00);
        checkOutput("rst2_credits", {4'b0, credits}, 8'h04);
        applyStimulus(3'b000, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
        checkOutput("overflow_credits", {4'b0, credits}, 8'h04);
        checkOutput("overflow_err",     {7'b0, err}, 8'h01);

        // Illegal select codes with enable set: no send, err is set.
        pulseReset();
        checkOutput("rst3_err", {7'b0, err}, 8'h00);
        applyStimulus(3'b110, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("illegal110_valid",   {7'b0, valid_o}, 8'h00);
        checkOutput("illegal110_err",     {7'b0, err}, 8'h01);
        checkOutput("illegal110_credits", {4'b0, credits}, 8'h04);
        pulseReset();
        applyStimulus(3'b101, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("illegal101_err",     {7'b0, err}, 8'h01);
        checkOutput("illegal101_credits", {4'b0, credits}, 8'h04);

        // Reset while a flit is on the link at credits=2. The reset clears
        // everything without waiting for a clock edge.
        pulseReset();
        applyStimulus(3'b001, 1'b1, 1'b0, 8'h00, 1'b1, S_VAL);
        applyStimulus(3'b100, 1'b1, 1'b0, 8'h77, 1'b1, 8'h77);
        checkOutput("mid_pre_credits", {4'b0, credits}, 8'h02);
        checkOutput("mid_pre_valid",   {7'b0, valid_o}, 8'h01);
        port_enable = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_valid",   {7'b0, valid_o}, 8'h00);
        checkOutput("mid_credits", {4'b0, credits}, 8'h04);
        checkOutput("mid_turn",    {3'b0, turn}, 8'h10);
        checkOutput("mid_data",    data_o, 8'h00);
        checkOutput("mid_full",    {7'b0, port_full}, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Every queued flit must have been seen by the monitor.
        checkOutput("scoreboard_drained", 8'(sb.size()), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
